// File: rtl/seg7_scan_if.sv
// Load-side bus of the seven-segment scan driver: digit data, per-digit enables/DPs,
// brightness and the load strobe. Optional build macro of the driver: SEG7_LEADING_ZERO_BLANK_EN.
interface seg7_scan_if #(
    parameter int NUM_DIGITS = 8
);
    // load is a one-cycle strobe with no ready: the driver always accepts it, capturing
    // digits/digit_en/dp on that cycle. brightness is level-sampled every cycle.
    logic [4*NUM_DIGITS-1:0] digits;
    logic [NUM_DIGITS-1:0]   digit_en;
    logic [NUM_DIGITS-1:0]   dp;
    logic [3:0]              brightness;
    logic                    load;

    modport master (
        output digits,
        output digit_en,
        output dp,
        output brightness,
        output load
    );

    modport slave (
        input digits,
        input digit_en,
        input dp,
        input brightness,
        input load
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// N-digit multiplexed seven-segment scan driver with PWM brightness, ghosting guard and
// frame-synchronous loading. Optional leading-zero blanking: define SEG7_LEADING_ZERO_BLANK_EN.
module seg7_scan_driver #(
    parameter int NUM_DIGITS  = 8,
    parameter int CLK_HZ      = 100_000_000,
    parameter int REFRESH_HZ  = 480,
    parameter int GUARD       = 4,
    parameter int AN_ACT_LOW  = 1,
    parameter int SEG_ACT_LOW = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    seg7_scan_if.slave            bus,
    output logic [NUM_DIGITS-1:0] anode,
    output logic [6:0]            display,
    output logic                  dp_out,
    output logic                  frame_done,
    output logic                  dbg_state
);

    localparam int DIV   = CLK_HZ / REFRESH_HZ;
    localparam int SUB   = DIV / 16;
    localparam int SUB_W = (SUB > 1) ? $clog2(SUB) : 1;
    localparam int IDX_W = $clog2(NUM_DIGITS);

    localparam logic [SUB_W-1:0] SUB_MAX  = SUB_W'(SUB - 1);
    localparam logic [IDX_W-1:0] IDX_MAX  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [SUB_W:0]   GUARD_L  = (SUB_W + 1)'(GUARD);
    localparam logic [NUM_DIGITS-1:0] AN_OFF =
        (AN_ACT_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
    localparam logic [6:0]       SEG_OFF  = (SEG_ACT_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic             DP_OFF   = (SEG_ACT_LOW != 0);

    typedef enum logic {
        ST_GUARD = 1'b0,
        ST_DRIVE = 1'b1
    } state_t;

    // Active-high segment pattern {a,b,c,d,e,f,g}; b and d are lowercase.
    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'b1111110;
            4'h1: s = 7'b0110000;
            4'h2: s = 7'b1101101;
            4'h3: s = 7'b1111001;
            4'h4: s = 7'b0110011;
            4'h5: s = 7'b1011011;
            4'h6: s = 7'b1011111;
            4'h7: s = 7'b1110000;
            4'h8: s = 7'b1111111;
            4'h9: s = 7'b1111011;
            4'hA: s = 7'b1110111;
            4'hB: s = 7'b0011111;
            4'hC: s = 7'b1001110;
            4'hD: s = 7'b0111101;
            4'hE: s = 7'b1001111;
            default: s = 7'b1000111;
        endcase
        return s;
    endfunction

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    // Keep digit i only if it or some higher nibble is nonzero; digit 0 always kept.
    function automatic logic [NUM_DIGITS-1:0] lz_mask(input logic [4*NUM_DIGITS-1:0] d);
        logic [NUM_DIGITS-1:0] m;
        logic                  seen;
        m    = '0;
        seen = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            seen = seen | (d[4*i +: 4] != 4'h0);
            m[i] = seen | (i == 0);
        end
        return m;
    endfunction
`endif

    // Scan position: sub_cnt -> PWM step -> digit index, each carrying into the next.
    logic [SUB_W-1:0] sub_q, sub_d;
    logic [3:0]       step_q, step_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    state_t           state_q, state_d;

    logic [4*NUM_DIGITS-1:0] pend_digits_q, pend_digits_d;
    logic [NUM_DIGITS-1:0]   pend_en_q, pend_en_d;
    logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
    logic [4*NUM_DIGITS-1:0] act_digits_q, act_digits_d;
    logic [NUM_DIGITS-1:0]   act_en_q, act_en_d;
    logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d;

    logic [NUM_DIGITS-1:0] anode_q, anode_d;
    logic [6:0]            display_q, display_d;
    logic                  dp_out_q, dp_out_d;
    logic                  frame_done_q, frame_done_d;

    logic                  frame_end;
    logic                  lit;
    logic [3:0]            cur_nib;
    logic [6:0]            cur_seg;
    logic [NUM_DIGITS-1:0] sel;

    always_comb begin
        sub_d     = sub_q;
        step_d    = step_q;
        idx_d     = idx_q;
        frame_end = (sub_q == SUB_MAX) && (step_q == 4'd15) && (idx_q == IDX_MAX);
        if (sub_q == SUB_MAX) begin
            sub_d  = '0;
            step_d = step_q + 4'd1;
            if (step_q == 4'd15) begin
                idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
            end
        end else begin
            sub_d = sub_q + 1'b1;
        end
        // State follows the position the counters move to, so it stays aligned with them.
        state_d = ((step_d == 4'd0) && ({1'b0, sub_d} < GUARD_L)) ? ST_GUARD : ST_DRIVE;
    end

    always_comb begin
        pend_digits_d = pend_digits_q;
        pend_en_d     = pend_en_q;
        pend_dp_d     = pend_dp_q;
        act_digits_d  = act_digits_q;
        act_en_d      = act_en_q;
        act_dp_d      = act_dp_q;
        if (bus.load) begin
            pend_digits_d = bus.digits;
            pend_en_d     = bus.digit_en;
            pend_dp_d     = bus.dp;
        end
        // Commit uses the pending value from before this cycle; a coincident load waits a frame.
        if (frame_end) begin
            act_digits_d = pend_digits_q;
            act_dp_d     = pend_dp_q;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
            act_en_d     = pend_en_q & lz_mask(pend_digits_q);
`else
            act_en_d     = pend_en_q;
`endif
        end
    end

    always_comb begin
        sel          = '0;
        sel[idx_q]   = 1'b1;
        cur_nib      = act_digits_q[{idx_q, 2'b00} +: 4];
        cur_seg      = hex7(cur_nib);
        lit          = (state_q == ST_DRIVE) && (step_q <= bus.brightness) && act_en_q[idx_q];
        anode_d      = AN_OFF;
        display_d    = SEG_OFF;
        dp_out_d     = DP_OFF;
        frame_done_d = frame_end;
        if (lit) begin
            anode_d   = AN_OFF ^ sel;
            display_d = SEG_OFF ^ cur_seg;
            dp_out_d  = DP_OFF ^ act_dp_q[idx_q];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sub_q         <= '0;
            step_q        <= '0;
            idx_q         <= '0;
            state_q       <= ST_GUARD;
            pend_digits_q <= '0;
            pend_en_q     <= '0;
            pend_dp_q     <= '0;
            act_digits_q  <= '0;
            act_en_q      <= '0;
            act_dp_q      <= '0;
            anode_q       <= AN_OFF;
            display_q     <= SEG_OFF;
            dp_out_q      <= DP_OFF;
            frame_done_q  <= 1'b0;
        end else begin
            sub_q         <= sub_d;
            step_q        <= step_d;
            idx_q         <= idx_d;
            state_q       <= state_d;
            pend_digits_q <= pend_digits_d;
            pend_en_q     <= pend_en_d;
            pend_dp_q     <= pend_dp_d;
            act_digits_q  <= act_digits_d;
            act_en_q      <= act_en_d;
            act_dp_q      <= act_dp_d;
            anode_q       <= anode_d;
            display_q     <= display_d;
            dp_out_q      <= dp_out_d;
            frame_done_q  <= frame_done_d;
        end
    end

    assign anode      = anode_q;
    assign display    = display_q;
    assign dp_out     = dp_out_q;
    assign frame_done = frame_done_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: 4 digits, DIV=32, SUB=2, GUARD=1, active-low pins.
// Expectations for the blanking case follow SEG7_LEADING_ZERO_BLANK_EN when defined.
module tb_seg7_scan_driver;

    localparam int ND = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [ND-1:0] anode;
    logic [6:0]    display;
    logic          dp_out;
    logic          frame_done;
    logic          dbg_state;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    int a0, a1, a2, a3, nfd;

    seg7_scan_if #(.NUM_DIGITS(ND)) bus_if ();

    seg7_scan_driver #(
        .NUM_DIGITS (ND),
        .CLK_HZ     (3200),
        .REFRESH_HZ (100),
        .GUARD      (1),
        .AN_ACT_LOW (1),
        .SEG_ACT_LOW(1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus_if.slave),
        .anode     (anode),
        .display   (display),
        .dp_out    (dp_out),
        .frame_done(frame_done),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: cycle count = posedges since reset release; sampling happens at negedge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) tick();
    endtask

    // Per-anode asserted-cycle counts and frame_done pulses over cycles from..to inclusive.
    task automatic scan(input int from, input int to,
                        output int c0, output int c1, output int c2, output int c3,
                        output int cf);
        c0 = 0; c1 = 0; c2 = 0; c3 = 0; cf = 0;
        run_to(from);
        while (1) begin
            if (anode[0] === 1'b0) c0++;
            if (anode[1] === 1'b0) c1++;
            if (anode[2] === 1'b0) c2++;
            if (anode[3] === 1'b0) c3++;
            if (frame_done === 1'b1) cf++;
            if (cyc >= to) break;
            tick();
        end
    endtask

    task automatic load_vec(input logic [15:0] d, input logic [3:0] en, input logic [3:0] p);
        bus_if.digits   = d;
        bus_if.digit_en = en;
        bus_if.dp       = p;
        bus_if.load     = 1'b1;
        tick();
        bus_if.load     = 1'b0;
    endtask

    initial begin
        bus_if.digits     = '0;
        bus_if.digit_en   = '0;
        bus_if.dp         = '0;
        bus_if.brightness = 4'd15;
        bus_if.load       = 1'b0;
        reset             = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_anode", anode, 4'hF);
        check("rst_display", display, 7'h7F);
        check("rst_dp", dp_out, 1'b1);
        check("rst_frame_done", frame_done, 1'b0);
        check("rst_state", dbg_state, 1'b0);

        // Release; first frame stays dark since active regs start cleared.
        reset = 1'b1;
        cyc   = 0;
        load_vec(16'h1234, 4'hF, 4'b0001);
        scan(1, 127, a0, a1, a2, a3, nfd);
        check("frame1_dark", a0 + a1 + a2 + a3, 0);
        check("frame1_no_fd", nfd, 0);
        run_to(128);
        check("fd_first", frame_done, 1'b1);
        check("state_guard_at_slot0", dbg_state, 1'b0);
        run_to(129);
        check("guard_anode", anode, 4'hF);
        check("fd_one_cycle", frame_done, 1'b0);
        check("state_drive", dbg_state, 1'b1);
        run_to(130);
        check("slot0_anode", anode, 4'b1110);
        check("slot0_disp_4", display, 7'b1001100);
        check("slot0_dp_lit", dp_out, 1'b0);
        run_to(163);
        check("slot1_anode", anode, 4'b1101);
        check("slot1_disp_3", display, 7'b0000110);
        run_to(195);
        check("slot2_anode", anode, 4'b1011);
        check("slot2_disp_2", display, 7'b0010010);
        run_to(227);
        check("slot3_anode", anode, 4'b0111);
        check("slot3_disp_1", display, 7'b1001111);
        check("slot3_dp_unlit", dp_out, 1'b1);

        // PWM duty.
        bus_if.brightness = 4'd3;
        scan(257, 288, a0, a1, a2, a3, nfd);
        check("bright3_slot0", a0, 7);
        scan(289, 320, a0, a1, a2, a3, nfd);
        check("bright3_slot1", a1, 7);
        bus_if.brightness = 4'd0;
        scan(385, 416, a0, a1, a2, a3, nfd);
        check("bright0_slot0", a0, 1);

        // Per-digit enable; frame period unchanged.
        bus_if.brightness = 4'd15;
        load_vec(16'h1234, 4'b0101, 4'b0000);
        run_to(512);
        check("fd_frame4", frame_done, 1'b1);
        scan(513, 640, a0, a1, a2, a3, nfd);
        check("en_anode0", a0, 31);
        check("en_anode1_off", a1, 0);
        check("en_anode2", a2, 31);
        check("en_anode3_off", a3, 0);
        check("en_fd_period", nfd, 1);
        check("fd_frame5", frame_done, 1'b1);

        // Mid-frame load is held until the frame boundary.
        run_to(700);
        load_vec(16'hABCD, 4'hF, 4'b0000);
        run_to(707);
        check("midload_old_anode", anode, 4'b1011);
        check("midload_old_disp", display, 7'b0010010);
        run_to(768);
        check("fd_frame6", frame_done, 1'b1);
        run_to(770);
        check("abcd_slot0_anode", anode, 4'b1110);
        check("abcd_slot0_d", display, 7'b1000010);
        run_to(867);
        check("abcd_slot3_anode", anode, 4'b0111);
        check("abcd_slot3_a", display, 7'b0001000);

        // Load on the frame_done cycle commits one frame later.
        run_to(896);
        check("fd_frame7", frame_done, 1'b1);
        load_vec(16'h5678, 4'hF, 4'b0000);
        run_to(898);
        check("fdload_held_anode", anode, 4'b1110);
        check("fdload_held_d", display, 7'b1000010);
        run_to(1024);
        check("fd_frame8", frame_done, 1'b1);
        run_to(1026);
        check("fdload_slot0_8", display, 7'b0000000);
        run_to(1059);
        check("fdload_slot1_anode", anode, 4'b1101);
        check("fdload_slot1_7", display, 7'b0001111);

        // Leading zeros.
        run_to(1100);
        load_vec(16'h0070, 4'hF, 4'b0000);
        run_to(1154);
        check("lz_slot0_anode", anode, 4'b1110);
        check("lz_slot0_0", display, 7'b0000001);
        run_to(1187);
        check("lz_slot1_anode", anode, 4'b1101);
        check("lz_slot1_7", display, 7'b0001111);
        run_to(1219);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        check("lz_slot2_anode", anode, 4'hF);
        check("lz_slot2_disp", display, 7'h7F);
`else
        check("lz_slot2_anode", anode, 4'b1011);
        check("lz_slot2_disp", display, 7'b0000001);
`endif
        run_to(1251);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        check("lz_slot3_anode", anode, 4'hF);
        check("lz_slot3_disp", display, 7'h7F);
`else
        check("lz_slot3_anode", anode, 4'b0111);
        check("lz_slot3_disp", display, 7'b0000001);
`endif

        // Asynchronous reset while a digit is lit.
        run_to(1283);
        check("pre_reset_anode", anode, 4'b1110);
        #2 reset = 1'b0;
        #1;
        check("midrst_anode", anode, 4'hF);
        check("midrst_display", display, 7'h7F);
        check("midrst_dp", dp_out, 1'b1);
        check("midrst_fd", frame_done, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        cyc   = 0;
        scan(1, 127, a0, a1, a2, a3, nfd);
        check("post_rst_dark", a0 + a1 + a2 + a3, 0);
        check("post_rst_no_fd", nfd, 0);
        run_to(128);
        check("post_rst_fd", frame_done, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
